// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: descriptor field widths,
// FSM state encoding, the latched descriptor record and an index-width helper.
package i2c_pkg;

  // Width of a 7-bit I2C slave address.
  localparam int ADDR_W = 7;

  // Width of a transfer byte count.
  localparam int CT_W = 8;

  // Arbiter FSM states. The encoding is fixed so state dumps read consistently.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // One requester's transaction descriptor, as presented to the I2C master.
  typedef struct packed {
    logic              rw;       // 0 write, 1 read
    logic [ADDR_W-1:0] s_add;    // slave address
    logic [CT_W-1:0]   byte_ct;  // number of bytes; 0 is rejected
  } desc_t;

  // Bits needed to index n items. Never less than one bit, so a single
  // requester still gets a legal vector width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Bundle of the requester-side and I2C-master-side signals of the arbiter.
// The slave modport is the arbiter's own view: it serves requesters and
// drives the descriptor into the I2C master. The master modport is the view
// of the surrounding logic (requesters plus the I2C master) that drives the
// requests and the completion pulse.
interface i2c_req_arbiter_if
  import i2c_pkg::*;
#(
  parameter int NREQ = 4
);

  // Requester side: level requests and packed per-requester descriptors.
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        rw_i;
  logic [ADDR_W*NREQ-1:0] s_add_i;
  logic [CT_W*NREQ-1:0]   byte_ct_i;

  // Requester side: grant level and completion / error pulses.
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        err;

  // I2C master side: start pulse, descriptor, and end-of-transfer pulse.
  logic                   m_st;
  logic                   m_rw;
  logic [ADDR_W-1:0]      m_s_add;
  logic [CT_W-1:0]        m_byte_ct;
  logic                   m_done;

  modport slave (
    input  req, rw_i, s_add_i, byte_ct_i, m_done,
    output gnt, done, err, m_st, m_rw, m_s_add, m_byte_ct
  );

  modport master (
    output req, rw_i, s_add_i, byte_ct_i, m_done,
    input  gnt, done, err, m_st, m_rw, m_s_add, m_byte_ct
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin picker: purely combinational. Scans the request vector
// starting at ptr, wrapping modulo NREQ, and reports the first requester
// found as a one-hot vector, as an index, and with a valid flag.
module rr_pick
  import i2c_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin : p_pick
    int cand;
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr is always below NREQ, so one conditional subtract is the wrap.
      cand = int'(ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!valid && req[IW'(cand)]) begin
        valid              = 1'b1;
        idx                = IW'(cand);
        winner[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// I2C request arbiter: shares one I2C master among NREQ requesters.
// Round-robin selection, one transaction at a time through the states
// IDLE -> GRANT -> LAUNCH -> WAIT -> RELEASE. A zero byte count is rejected
// in GRANT with an err pulse and never reaches the master.
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TO_CYCLES clocks that ends a stuck transfer with err instead of done.
// Without the macro WAIT waits for m_done indefinitely.
//
// Reset rs is synchronous and active-low; the I2C master must share it,
// because a reset in mid-transfer is abandoned silently.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rs,
  i2c_req_arbiter_if.slave    bus
);

  localparam int IW = idx_w(NREQ);

  // A watchdog limit below 2 cycles could never count; refuse to build.
  if (TO_CYCLES < 2) begin : g_bad_to_cycles
    $error("i2c_req_arbiter: TO_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Requester descriptors, unpacked from the flat buses
  // ---------------------------------------------------------------------------
  desc_t in_desc [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign in_desc[k] = {bus.rw_i[k],
                         bus.s_add_i[k*ADDR_W +: ADDR_W],
                         bus.byte_ct_i[k*CT_W +: CT_W]};
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // ---------------------------------------------------------------------------
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  desc_t           pick_desc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_desc = in_desc[pick_idx];

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            st_q, st_d;
  desc_t           desc_q, desc_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = idx_w(TO_CYCLES);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // The winner latched in GRANT, as a one-hot mask for done/err pulses.
  assign win_oh = NREQ'(1) << win_q;

  // Next-state and next-output logic. done, err and m_st are pulses, so they
  // default low every cycle; gnt and the descriptor hold unless changed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    st_d    = 1'b0;
    desc_d  = desc_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          win_d   = pick_idx;
          // The pointer advances past the winner even if it is rejected, so a
          // requester stuck on a zero count cannot starve the others.
          ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          desc_d  = pick_desc;
          // A zero-byte request is refused: err is visible in the GRANT cycle
          // and gnt never rises for it.
          if (pick_desc.byte_ct == '0) begin
            err_d = pick_oh;
          end else begin
            gnt_d = pick_oh;
          end
        end
      end

      ST_GRANT: begin
        if (desc_q.byte_ct == '0) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          desc_d  = '0;
        end else begin
          state_d = ST_LAUNCH;
          st_d    = 1'b1;
        end
      end

      ST_LAUNCH: begin
        state_d = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      ST_WAIT: begin
        // m_done wins over a watchdog expiry in the same cycle.
        if (bus.m_done) begin
          state_d = ST_RELEASE;
          done_d  = win_oh;
          gnt_d   = '0;
          desc_d  = '0;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          err_d   = win_oh;
          gnt_d   = '0;
          desc_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_RELEASE: begin
        // One bus-free cycle before the next arbitration.
        state_d = ST_IDLE;
        gnt_d   = '0;
        desc_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        desc_d  = '0;
      end
    endcase
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous: rs is tested inside the clocked block,
    // so it only takes effect on a rising clk edge, like any other data input.
    if (!rs) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      st_q    <= 1'b0;
      desc_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      st_q    <= st_d;
      desc_q  <= desc_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.m_st      = st_q;
  assign bus.m_rw      = desc_q.rw;
  assign bus.m_s_add   = desc_q.s_add;
  assign bus.m_byte_ct = desc_q.byte_ct;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter. A transaction-level reference
// model (round-robin pointer plus the cycle timeline of a transfer) predicts
// every output vector; stimulus is randomized with $urandom.
// Honors I2C_ARB_TIMEOUT_EN the same way as the design.
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int NREQ = 4;
  localparam int OW   = 3 * NREQ + 2 + ADDR_W + CT_W;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO   = 16;
  localparam int MAXW = 12;
  localparam int SINGLE_WAIT = 10;
`else
  localparam int TO   = 4096;
  localparam int MAXW = 24;
  localparam int SINGLE_WAIT = 17;
`endif

  logic clk = 1'b0;
  logic rs  = 1'b0;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_req_arbiter #(
    .NREQ      (NREQ),
    .TO_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: next round-robin starting point.
  int ptr_m = 0;

  // Current stimulus values.
  logic [NREQ-1:0]   cur_req;
  logic [NREQ-1:0]   cur_rw;
  logic [ADDR_W-1:0] cur_add [NREQ];
  logic [CT_W-1:0]   cur_ct  [NREQ];

  task automatic drive();
    bus.req  = cur_req;
    bus.rw_i = cur_rw;
    for (int k = 0; k < NREQ; k++) begin
      bus.s_add_i[k*ADDR_W +: ADDR_W] = cur_add[k];
      bus.byte_ct_i[k*CT_W +: CT_W]   = cur_ct[k];
    end
  endtask

  task automatic rand_desc(input bit allow_zero);
    cur_rw = NREQ'($urandom);
    for (int k = 0; k < NREQ; k++) begin
      cur_add[k] = ADDR_W'($urandom);
      cur_ct[k]  = (allow_zero && $urandom_range(0, 4) == 0) ? '0 : CT_W'($urandom_range(1, 255));
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner = first requesting index in the rotated order ptr_m, ptr_m+1, ...
  function automatic int model_pick(input logic [NREQ-1:0] r);
    int order [$];
    for (int i = 0; i < NREQ; i++) order.push_back((ptr_m + i) % NREQ);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {bus.gnt, bus.done, bus.err, bus.m_st, bus.m_rw, bus.m_s_add, bus.m_byte_ct};
  endfunction

  function automatic logic [OW-1:0] pack(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                                         input logic [NREQ-1:0] e, input logic st, input logic rw,
                                         input logic [ADDR_W-1:0] a, input logic [CT_W-1:0] c);
    return {g, d, e, st, rw, a, c};
  endfunction

  // One full arbitration, starting in an IDLE cycle. wait_n WAIT cycles pass
  // before m_done; drop releases the winner's req after GRANT; stray pulses
  // m_done during GRANT, where it must be ignored.
  task automatic run_txn(input int wait_n, input bit drop, input bit stray, input string tag);
    int                w;
    logic [NREQ-1:0]   oh;
    logic              rw_s;
    logic [ADDR_W-1:0] a_s;
    logic [CT_W-1:0]   c_s;
    logic [OW-1:0]     obs, exp;

    drive();
    obs = outs(); exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s/idle: got %h want %h", tag, obs, exp); end

    w = model_pick(cur_req);
    if (w < 0) return;
    oh   = NREQ'(1) << w;
    rw_s = cur_rw[w];
    a_s  = cur_add[w];
    c_s  = cur_ct[w];
    ptr_m = (w + 1) % NREQ;

    tick();  // GRANT
    obs = outs();
    exp = (c_s == '0) ? pack('0, '0, oh, 1'b0, rw_s, a_s, c_s) : pack(oh, '0, '0, 1'b0, rw_s, a_s, c_s);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s/grant: got %h want %h", tag, obs, exp); end

    // Late input changes must not reach the descriptor.
    bus.m_done = stray;
    rand_desc(1'b1);
    if (drop) cur_req[w] = 1'b0;
    drive();

    if (c_s == '0) begin
      tick();  // RELEASE after rejection
      bus.m_done = 1'b0;
      obs = outs(); exp = '0;
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s/reject-release: got %h want %h", tag, obs, exp); end
      tick();
      return;
    end

    tick();  // LAUNCH
    bus.m_done = 1'b0;
    obs = outs(); exp = pack(oh, '0, '0, 1'b1, rw_s, a_s, c_s);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s/launch: got %h want %h", tag, obs, exp); end

    tick();  // first WAIT cycle
    obs = outs(); exp = pack(oh, '0, '0, 1'b0, rw_s, a_s, c_s);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s/wait: got %h want %h", tag, obs, exp); end

    repeat (wait_n) begin
      tick();
      obs = outs();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s/hold: got %h want %h", tag, obs, exp); end
    end

    bus.m_done = 1'b1;
    tick();  // RELEASE with done pulse
    bus.m_done = 1'b0;
    obs = outs(); exp = pack('0, oh, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s/done: got %h want %h", tag, obs, exp); end

    tick();  // back in IDLE
  endtask

  task automatic test_reset();
    logic [OW-1:0] obs;
    rs = 1'b0;
    bus.m_done = 1'b0;
    cur_req = '1;
    rand_desc(1'b0);
    drive();
    repeat (3) begin
      tick();
      obs = outs();
      n_checks++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset: got %h want 0", obs); end
    end
    rs = 1'b1;
    cur_req = '0;
    drive();
    ptr_m = 0;
    tick();
    obs = outs();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset/idle-after: got %h want 0", obs); end
  endtask

  task automatic test_round_robin();
    cur_req = '1;
    for (int i = 0; i < 5; i++) begin
      rand_desc(1'b0);
      run_txn($urandom_range(0, MAXW), 1'b0, 1'b0, "round_robin");
    end
    cur_req = '0;
    drive();
  endtask

  task automatic test_single();
    rand_desc(1'b0);
    cur_req    = 4'b0001;
    cur_rw[0]  = 1'b0;
    cur_add[0] = 7'h50;
    cur_ct[0]  = 8'd3;
    run_txn(SINGLE_WAIT, 1'b0, 1'b0, "single");
    cur_req = '0;
    drive();
  endtask

  task automatic test_reject();
    rand_desc(1'b0);
    cur_req   = 4'b0100;
    cur_ct[2] = '0;
    run_txn(0, 1'b0, 1'b0, "reject");
    rand_desc(1'b0);
    cur_req = '1;
    run_txn($urandom_range(0, MAXW), 1'b0, 1'b0, "after_reject");
    cur_req = '0;
    drive();
  endtask

  task automatic test_stray_done();
    logic [OW-1:0] obs;
    cur_req = '0;
    drive();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    obs = outs();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL stray_idle: got %h want 0", obs); end
    rand_desc(1'b0);
    cur_req = NREQ'($urandom_range(1, 15));
    run_txn($urandom_range(0, MAXW), 1'b1, 1'b1, "stray_grant");
    cur_req = '0;
    drive();
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] obs;
    rand_desc(1'b0);
    cur_req = 4'b0010;
    drive();
    ptr_m = 2;
    repeat (4) tick();  // GRANT, LAUNCH, WAIT, WAIT
    rs = 1'b0;
    bus.m_done = 1'b1;
    cur_req = '0;
    drive();
    tick();
    rs = 1'b1;
    bus.m_done = 1'b0;
    ptr_m = 0;
    obs = outs();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL mid_reset/abort: got %h want 0", obs); end
    tick();
    obs = outs();
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL mid_reset/no_done: got %h want 0", obs); end
    rand_desc(1'b0);
    cur_req = '1;
    run_txn($urandom_range(0, MAXW), 1'b0, 1'b0, "after_mid_reset");
    cur_req = '0;
    drive();
  endtask

  task automatic test_timeout();
    logic [OW-1:0] obs, hold;
    logic [NREQ-1:0] oh;
    int w;
    rand_desc(1'b0);
    cur_req = 4'b1000;
    drive();
    w  = model_pick(cur_req);
    oh = NREQ'(1) << w;
    hold = pack(oh, '0, '0, 1'b0, cur_rw[w], cur_add[w], cur_ct[w]);
    ptr_m = (w + 1) % NREQ;
    repeat (3) tick();  // now in the first WAIT cycle (cycle 3)
    cur_req = '0;
    drive();
`ifdef I2C_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      obs = outs();
      n_checks++;
      if (obs !== hold) begin n_fail++; $display("FAIL timeout/hold k=%0d: got %h want %h", k, obs, hold); end
      tick();
    end
    obs = outs();
    n_checks++;
    if (obs !== pack('0, '0, oh, 1'b0, 1'b0, '0, '0)) begin
      n_fail++; $display("FAIL timeout/err: got %h want %h", obs, pack('0, '0, oh, 1'b0, 1'b0, '0, '0));
    end
    tick();
`else
    begin
      int bad = 0;
      for (int cyc = 3; cyc < 1000; cyc++) begin
        if (outs() !== hold) bad++;
        tick();
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL no_timeout/hold: %0d bad cycles, want 0", bad); end
      obs = outs();
      n_checks++;
      if (obs !== hold) begin n_fail++; $display("FAIL no_timeout/cycle1000: got %h want %h", obs, hold); end
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      obs = outs();
      n_checks++;
      if (obs !== pack('0, oh, '0, 1'b0, 1'b0, '0, '0)) begin
        n_fail++; $display("FAIL no_timeout/done: got %h want %h", obs, pack('0, oh, '0, 1'b0, 1'b0, '0, '0));
      end
      tick();
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      rand_desc(1'b1);
      cur_req = NREQ'($urandom_range(1, 15));
      run_txn($urandom_range(0, MAXW), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
    cur_req = '0;
    drive();
  endtask

  initial begin
    bus.m_done = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_reject();
    test_stray_done();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "simulation time limit");
  end

endmodule
